// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared types for the pipelined adder:
//   op_e       operation select (ADD / SUB / ADC / SBC)
//   nzcv_t     packed {n,z,c,v} flag bundle, n in the MSB
//   seg_width  segment width derivation (WIDTH split evenly over STAGES)
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBC = 2'd3
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // WIDTH must be a multiple of STAGES; each stage adds one slice this wide.
    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// ---------------------------------------------------------------------------
// adder_seg
// Combinational SEG-bit ripple slice. One instance per pipeline stage.
// Ports:
//   a, b   in   SEG-bit segment operands
//   cin    in   carry into bit 0 of the slice
//   s      out  SEG-bit segment sum
//   cout   out  carry out of the slice MSB
//   c_msb  out  carry into the slice MSB (overflow detection in the top slice)
// ---------------------------------------------------------------------------
module adder_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] carry;

    assign carry[0] = cin;

    genvar i;
    for (i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    assign cout  = carry[SEG];
    assign c_msb = carry[SEG-1];

endmodule

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell used to build the segment carry chain.
// Ports:
//   a, b  in   addend bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit add/subtract split into STAGES carry-chained segments, one
// segment per registered stage, with ARM ADD/SUB/ADC/SBC semantics, NZCV
// flags and a valid/ready handshake. The whole pipe advances or holds as a
// unit: advance = !out_valid || out_ready, and in_ready = advance.
//
// Optional build macro ADDER_SAT_EN: adds the sat_en input, carried along
// with each bundle; in the final stage an overflowing result is clamped to
// the signed bound (v and c kept, n and z follow the clamped sum).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand bundle valid
//   in_ready   out  bundle accepted this cycle when in_valid is high
//   a, b       in   WIDTH-bit operands
//   c_in       in   carry flag (ADC/SBC only)
//   op         in   op_e operation
//   sat_en     in   saturate on signed overflow (ADDER_SAT_EN only)
//   out_valid  out  result valid
//   out_ready  in   consumer takes result
//   sum        out  WIDTH-bit result
//   flags      out  nzcv_t {n,z,c,v}
// ---------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  op_e              op,
`ifdef ADDER_SAT_EN
    input  logic             sat_en,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output nzcv_t            flags
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operand prep: subtraction is a + ~b + 1; SBC uses the carry flag as
    // the inverted borrow.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    always_comb begin
        b_eff   = b;
        cin_eff = 1'b0;
        case (op)
            OP_ADD: begin
                b_eff   = b;
                cin_eff = 1'b0;
            end
            OP_SUB: begin
                b_eff   = ~b;
                cin_eff = 1'b1;
            end
            OP_ADC: begin
                b_eff   = b;
                cin_eff = c_in;
            end
            OP_SBC: begin
                b_eff   = ~b;
                cin_eff = c_in;
            end
            default: begin
                b_eff   = b;
                cin_eff = 1'b0;
            end
        endcase
    end

    // Stage k adds segment k. Operands still to be added travel shifted down
    // so the active segment always sits at bits [SEG-1:0]; finished sum
    // segments accumulate above the ones already done.
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * SEG;
        localparam int DONE = (k + 1) * SEG;

        logic [REM-1:0]  src_a;
        logic [REM-1:0]  src_b;
        logic            src_valid;
        logic            src_carry;
        logic            src_zero;
        logic [DONE-1:0] sum_d;
        logic [SEG-1:0]  seg_s;
        logic            seg_cout;
        logic            seg_cmsb;
        logic            zero_d;
`ifdef ADDER_SAT_EN
        logic            src_sat;
`endif

        if (k == 0) begin : g_src
            assign src_a     = a;
            assign src_b     = b_eff;
            assign src_valid = in_valid;
            assign src_carry = cin_eff;
            assign src_zero  = 1'b1;
            assign sum_d     = seg_s;
`ifdef ADDER_SAT_EN
            assign src_sat   = sat_en;
`endif
        end else begin : g_src
            assign src_a     = g_stage[k-1].g_mid.a_q;
            assign src_b     = g_stage[k-1].g_mid.b_q;
            assign src_valid = g_stage[k-1].g_mid.valid_q;
            assign src_carry = g_stage[k-1].g_mid.carry_q;
            assign src_zero  = g_stage[k-1].g_mid.zero_q;
            assign sum_d     = {seg_s, g_stage[k-1].g_mid.sum_q};
`ifdef ADDER_SAT_EN
            assign src_sat   = g_stage[k-1].g_mid.sat_q;
`endif
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a     (src_a[SEG-1:0]),
            .b     (src_b[SEG-1:0]),
            .cin   (src_carry),
            .s     (seg_s),
            .cout  (seg_cout),
            .c_msb (seg_cmsb)
        );

        assign zero_d = src_zero & (seg_s == '0);

        if (k < STAGES - 1) begin : g_mid
            logic               valid_q;
            logic               carry_q;
            logic               zero_q;
            logic [DONE-1:0]    sum_q;
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] b_q;
`ifdef ADDER_SAT_EN
            logic               sat_q;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    zero_q  <= 1'b0;
                    sum_q   <= '0;
                    a_q     <= '0;
                    b_q     <= '0;
`ifdef ADDER_SAT_EN
                    sat_q   <= 1'b0;
`endif
                end else if (advance) begin
                    valid_q <= src_valid;
                    carry_q <= seg_cout;
                    zero_q  <= zero_d;
                    sum_q   <= sum_d;
                    a_q     <= src_a[REM-1:SEG];
                    b_q     <= src_b[REM-1:SEG];
`ifdef ADDER_SAT_EN
                    sat_q   <= src_sat;
`endif
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] res_d;
            nzcv_t            flags_d;
            logic             valid_q;
            logic [WIDTH-1:0] sum_q;
            nzcv_t            flags_q;
`ifdef ADDER_SAT_EN
            localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
            localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;
`endif

            always_comb begin
                res_d     = sum_d;
                flags_d.n = sum_d[WIDTH-1];
                flags_d.z = zero_d;
                flags_d.c = seg_cout;
                flags_d.v = seg_cmsb ^ seg_cout;
`ifdef ADDER_SAT_EN
                // A positive overflow wraps to a negative-looking sum, so the
                // wrapped sign picks the bound.
                if (src_sat && flags_d.v) begin
                    res_d     = sum_d[WIDTH-1] ? MAX_POS : MIN_NEG;
                    flags_d.n = res_d[WIDTH-1];
                    flags_d.z = (res_d == '0);
                end
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    sum_q   <= '0;
                    flags_q <= '0;
                end else if (advance) begin
                    valid_q <= src_valid;
                    sum_q   <= res_d;
                    flags_q <= flags_d;
                end
            end

            assign out_valid = valid_q;
            assign sum       = sum_q;
            assign flags     = flags_q;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif
    localparam longint TWO32 = 64'sh1_0000_0000;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    op_e              op;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    nzcv_t            flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int first_pop = 0;
    int last_pop = 0;
    logic [35:0] cur_exp;
    logic [35:0] exp_q[$];
    logic [31:0] hold_sum;
    nzcv_t       hold_flags;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
`ifdef ADDER_SAT_EN
        .sat_en    (sat_en),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the true unsigned/signed values.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input op_e o, input logic sat);
        longint ua, ub, sa, sb, ur, sr, cl, bw;
        logic [31:0] s;
        logic c, v;
        ua = longint'({32'd0, x});
        ub = longint'({32'd0, y});
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        cl = longint'({63'd0, ci});
        ur = 0; sr = 0; c = 1'b0; bw = 0;
        case (o)
            OP_ADD: begin ur = ua + ub; sr = sa + sb; c = (ur >= TWO32); end
            OP_SUB: begin ur = ua - ub; sr = sa - sb; c = (ua >= ub); end
            OP_ADC: begin ur = ua + ub + cl; sr = sa + sb + cl; c = (ur >= TWO32); end
            default: begin
                bw = 1 - cl;
                ur = ua - ub - bw; sr = sa - sb - bw; c = (ua >= ub + bw);
            end
        endcase
        s = ur[31:0];
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (sat && v) s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {s, s[31], (s == 32'd0), c, v};
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci,
                         input op_e o, input logic s);
        a = x; b = y; c_in = ci; op = o; sat_en = s; in_valid = 1'b1;
        cur_exp = model(x, y, ci, o, s & SAT_BUILD);
    endtask

    task automatic drive_exp(input logic [31:0] x, input logic [31:0] y, input logic ci,
                             input op_e o, input logic s, input logic [35:0] e);
        a = x; b = y; c_in = ci; op = o; sat_en = s; in_valid = 1'b1;
        cur_exp = e;
    endtask

    task automatic drive_rand();
        drive(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), op_e'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    endtask

    // One clock: score the output handshake and the input handshake that the
    // coming edge performs, then move to the next falling edge.
    task automatic tick();
        logic [35:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e[35:4]));
                check("flags", 64'(flags), 64'(e[3:0]));
                pops++;
                if (pops == 1) first_pop = cyc;
                last_pop = cyc;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(cur_exp);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; op = OP_ADD; sat_en = 1'b0; cur_exp = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: carry-out wrap to zero, with latency check.
        drive_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 1'b0, {32'h0, 4'b0110});
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            check("latency_early", 64'(out_valid), 64'd0);
            tick();
        end
        check("latency_valid", 64'(out_valid), 64'd1);

        // Directed: signed overflow on SUB, SBC with borrow in.
        drive_exp(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 1'b0, {32'h7FFF_FFFF, 4'b0011});
        tick();
        drive_exp(32'd5, 32'd3, 1'b0, OP_SBC, 1'b0, {32'd1, 4'b0010});
        tick();
        drain();

        // Back-to-back ADDs at full throughput.
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            drive($urandom, $urandom, 1'b0, OP_ADD, 1'b0);
            #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        drain();
        check("b2b_count", 64'(pops), 64'd8);
        check("b2b_consecutive", 64'(last_pop - first_pop), 64'd7);

        // Backpressure with a full pipe.
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            drive_rand();
            tick();
            n++;
        end
        check("stall_fill", 64'(out_valid), 64'd1);
        drive_rand();
        hold_sum = sum;
        hold_flags = flags;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_sum", 64'(sum), 64'(hold_sum));
            check("stall_flags", 64'(flags), 64'(hold_flags));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            tick();
        end
        drain();

        // Asynchronous reset with bundles in flight.
        out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            drive_rand();
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_sum", 64'(sum), 64'd0);
        check("async_rst_flags", 64'(flags), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < STAGES + 4; i++) begin
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
            tick();
        end

        // Random mix with random backpressure and bubbles.
        for (int i = 0; i < 80; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) drive_rand();
            else in_valid = 1'b0;
            tick();
        end
        drain();

`ifdef ADDER_SAT_EN
        drive_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 1'b1, {32'h7FFF_FFFF, 4'b0001});
        tick();
        drive_exp(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, OP_ADD, 1'b1, {32'h8000_0000, 4'b1011});
        tick();
        drive_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 1'b0, {32'h8000_0000, 4'b1001});
        tick();
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
